hpm_counter_unit: RTL
=====================

# hpm_counter_unit

Parametrised machine performance-counter block serving the Zicntr/Zihpm CSR address space: `mcycle`, `minstret`, up to 29 event counters `mhpmcounter3..31`, their `*h` upper halves and the read-only user shadows. It sits beside the CSR file, which forwards counter-range CSR accesses and reads back the result one cycle later. Extensions over the current fixed counter list:

- configurable counter width and count;
- multi-retire `minstret` increment (superscalar frontend);
- `mcountinhibit`;
- per-counter overflow pulses.

## Interface
Parameters:
- `XLEN`, 32, CSR data width.
- `CNT_WIDTH`, 64, counter width; must be greater than `XLEN` and at most 2*`XLEN`. Upper halves are mapped at +0x80.
- `NB_HPM`, 14, event counters implemented, indices 3..3+`NB_HPM`-1; range 0..29.
- `NB_RETIRE`, 2 (= `FRONTEND_WIDTH`), maximum instructions retired per cycle.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous active-low reset.
- `retire_cnt_i` in $clog2(`NB_RETIRE`+1): instructions retired this cycle; values above `NB_RETIRE` are clamped to `NB_RETIRE`.
- `event_i` in `NB_HPM`: bit k increments `mhpmcounter(3+k)` by 1.
- `csr_req_i` in 1: CSR access valid; one access may be issued per cycle.
- `csr_we_i` in 1: write (1) or read (0).
- `csr_addr_i` in 12: CSR address (`csr_reg_t` encoding).
- `csr_wdata_i` in `XLEN`: write data.
- `csr_ack_o` out 1: access completed, one cycle after `csr_req_i`.
- `csr_rdata_o` out `XLEN`: read data, valid with `csr_ack_o`; 0 on writes and errors.
- `csr_err_o` out 1: illegal access, valid with `csr_ack_o`.
- `ovf_o` out 3+`NB_HPM`: one-cycle pulse when a counter wraps. Bit 0 is cycle, bit 1 is tied 0, bit 2 is instret, bit 3+k is hpm k.

## Operation
**Counters**
- Every cycle:
  - `mcycle` increments by 1;
  - `minstret` increments by `retire_cnt_i`;
  - `mhpm(3+k)` increments by `event_i[k]`.
- Each counter is gated by its own `mcountinhibit` bit.
- Arithmetic is modulo 2^`CNT_WIDTH`. When a carry leaves the MSB, the matching `ovf_o` bit pulses on the next cycle.

**mcountinhibit (0x320)**
- Bit 0: CY. Bit 2: IR. Bits 3..3+`NB_HPM`-1: HPM.
- Bit 1 (TM) and bits for unimplemented counters read 0 and ignore writes.

**Address map**
- Machine, read/write:
  - 0xB00: cycle low.
  - 0xB02: instret low.
  - 0xB03+k: hpm k low.
  - Same offsets +0x80: upper `CNT_WIDTH`-`XLEN` bits, zero-extended on read.
- User, read-only: 0xC00, 0xC02, 0xC03+k, and the same offsets +0x80.
- Unimplemented hpm indices in machine space are WARL-zero: reads return 0, writes are ignored, no error.

**Errors**
`csr_err_o`=1 and no state change for:
- any write to the 0xC?? range;
- `time` (0xC01/0xC81);
- any unmapped address.

**Writes**
- A low-half write replaces bits [`XLEN`-1:0] and keeps the upper bits. A high-half write replaces the upper bits and keeps the low half.
- A write in the same cycle as an increment of that counter wins: the written value is stored and the increment is dropped.
- Writing a counter never produces `ovf_o`.

**Reads**
A read samples the registered value at the request cycle, i.e. before that cycle's increment.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - all counters, `mcountinhibit`, `csr_ack_o`, `csr_err_o`, `csr_rdata_o` and `ovf_o` go to 0;
  - counting resumes on the first rising edge after deassertion.
- Latency:
  - `csr_req_i` at edge n gives `csr_ack_o`/`csr_rdata_o`/`csr_err_o` valid for exactly cycle n+1;
  - a write is visible to a read issued at n+1;
  - back-to-back requests give back-to-back acks.
- Increment: the value seen by a read issued at n+1 includes the increment from cycle n.
- Overflow: a counter at all-ones with an increment at cycle n reads 0 at n+1 and `ovf_o` is high during n+1.
- `minstret` with `retire_cnt_i`=2 at all-ones-minus-0 reads 1 and pulses `ovf_o[2]`.
- An `mcountinhibit` write at cycle n stops or starts counting from cycle n+1. Cycle n's increment still uses the old inhibit value.

## Structure
- Add to the shared package:
  - `CSR_MCOUNTINHIBIT`=12'h320;
  - `CSR_MCYCLEH`=12'hB80, `CSR_MINSTRETH`=12'hB82, `CSR_CYCLEH`=12'hC80, `CSR_INSTRETH`=12'hC82;
  - `HPM_BASE`=3, `CSR_HIGH_OFFSET`=12'h080.
- Sub-module `hpm_counter`, parametrised by `CNT_WIDTH`/`XLEN`/increment width:
  - inputs: inc amount, inhibit, `we_lo`/`we_hi`, wdata;
  - outputs: value, ovf pulse.
- The top instantiates `hpm_counter` 2+`NB_HPM` times and holds address decode, the read mux and the response registers.

## Test plan
- **Reset, then idle:** release `reset_n`, wait 10 cycles, read 0xB00 → rdata 10 (±1 per the latency rule above); read 0xB02 → 0; `ovf_o`=0.
- **High-half write then wrap:** write 0xB80=0, then 0xB00=0xFFFFFFFE. Reads of 0xB00 return 0xFFFFFFFF, then 0x00000000. 0xB80 then reads 1. No `ovf_o`.
- **Full wrap, multi-retire:** preload `minstret`=2^64-1, drive `retire_cnt_i`=2 for one cycle → read 0xB02=1, 0xB82=0, `ovf_o[2]` pulses once.
- **Inhibit:** write 0x320=0x9 (CY and hpm3 inhibited), pulse `event_i[0]` 5× → `mcycle` and `mhpm3` frozen, `minstret` still counts. Reading 0x320 returns 0x9; writing 0x2 reads back 0.
- **Error paths:** write 0xC00 → ack, err=1, `mcycle` unchanged. Read 0xC01 → err=1, rdata=0. Read 0xB1F with `NB_HPM`=14 → rdata 0, err=0.
- **Collision and mid-op reset:**
  - write 0xB03=0x55 while `event_i[0]`=1 → reads 0x55;
  - assert `reset_n` low mid-request → no ack next cycle, all counters read 0 after release.

Source files
------------

// File: rtl/hpm_counter_unit_pkg.sv
// Shared CSR address constants and the counter-range decoder used by the
// performance-counter block.
package hpm_counter_unit_pkg;

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MCYCLE        = 12'hB00,
        CSR_MINSTRET      = 12'hB02,
        CSR_MHPMCOUNTER3  = 12'hB03,
        CSR_MCYCLEH       = 12'hB80,
        CSR_MINSTRETH     = 12'hB82,
        CSR_MHPMCOUNTER3H = 12'hB83,
        CSR_CYCLE         = 12'hC00,
        CSR_TIME          = 12'hC01,
        CSR_INSTRET       = 12'hC02,
        CSR_HPMCOUNTER3   = 12'hC03,
        CSR_CYCLEH        = 12'hC80,
        CSR_TIMEH         = 12'hC81,
        CSR_INSTRETH      = 12'hC82,
        CSR_HPMCOUNTER3H  = 12'hC83
    } csr_reg_t;

    localparam int unsigned HPM_BASE        = 3;
    localparam int unsigned IDX_TIME        = 1;
    localparam logic [11:0] CSR_HIGH_OFFSET = 12'h080;
    localparam logic [11:0] CNT_SPACE_MASK  = 12'hFE0;

    typedef enum logic [1:0] {
        SEL_ERR,
        SEL_ZERO,
        SEL_INHIBIT,
        SEL_COUNTER
    } csr_sel_e;

    typedef struct packed {
        csr_sel_e   sel;
        logic       high;
        logic [4:0] idx;
    } csr_dec_t;

    // Counter index is the low 5 address bits in both the machine and user pages.
    function automatic csr_dec_t csr_decode(input logic [11:0] addr,
                                            input logic        we,
                                            input int unsigned nb_hpm);
        csr_dec_t    d;
        logic [11:0] base;
        logic        user;
        base   = addr & ~CSR_HIGH_OFFSET;
        user   = (base & CNT_SPACE_MASK) == CSR_CYCLE;
        d.sel  = SEL_ERR;
        d.high = |(addr & CSR_HIGH_OFFSET);
        d.idx  = base[4:0];
        if (addr == CSR_MCOUNTINHIBIT) begin
            d.sel  = SEL_INHIBIT;
            d.high = 1'b0;
        end else if (user || (base & CNT_SPACE_MASK) == CSR_MCYCLE) begin
            if (user && we)
                d.sel = SEL_ERR;
            else if (d.idx == 5'(IDX_TIME))
                d.sel = SEL_ERR;
            else if (32'(d.idx) < HPM_BASE + nb_hpm)
                d.sel = SEL_COUNTER;
            else
                d.sel = SEL_ZERO;
        end
        return d;
    endfunction

endpackage

// File: rtl/hpm_counter_unit_counter.sv
// Single wrapping counter with inhibit, split low/high CSR writes and a
// registered carry-out pulse.
module hpm_counter #(
    parameter int unsigned CNT_WIDTH = 64,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [INC_WIDTH-1:0] inc,
    input  logic                 inhibit,
    input  logic                 we_lo,
    input  logic                 we_hi,
    input  logic [XLEN-1:0]      wdata,
    output logic [CNT_WIDTH-1:0] value,
    output logic                 ovf
);

    logic [CNT_WIDTH:0] sum;

    assign sum = {1'b0, value} + (CNT_WIDTH+1)'(inc);

    // A CSR write takes priority over the increment and never raises ovf.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (we_lo)
                value[XLEN-1:0] <= wdata;
            else if (we_hi)
                value[CNT_WIDTH-1:XLEN] <= wdata[CNT_WIDTH-XLEN-1:0];
            else if (!inhibit)
                {ovf, value} <= sum;
        end
    end

endmodule

// File: rtl/hpm_counter_unit.sv
// Machine performance counters (cycle, instret, hpm3..) with mcountinhibit,
// CSR decode/read mux and a one-cycle registered response.
module hpm_counter_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_WIDTH = 64,
    parameter int unsigned NB_HPM    = 14,
    parameter int unsigned NB_RETIRE = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [$clog2(NB_RETIRE+1)-1:0]   retire_cnt_i,
    input  logic [NB_HPM-1:0]                event_i,
    input  logic                             csr_req_i,
    input  logic                             csr_we_i,
    input  logic [11:0]                      csr_addr_i,
    input  logic [XLEN-1:0]                  csr_wdata_i,
    output logic                             csr_ack_o,
    output logic [XLEN-1:0]                  csr_rdata_o,
    output logic                             csr_err_o,
    output logic [2+NB_HPM:0]                ovf_o
);

    import hpm_counter_unit_pkg::*;

    localparam int unsigned RET_W  = $clog2(NB_RETIRE + 1);
    localparam int unsigned NB_CNT = HPM_BASE + NB_HPM;
    localparam logic [NB_CNT-1:0] INH_MASK = ~(NB_CNT'(2));

    csr_dec_t              dec;
    logic                  wr_cnt;
    logic                  wr_lo;
    logic                  wr_hi;
    logic                  wr_inh;
    logic [NB_CNT-1:0]     inhibit;
    logic [RET_W-1:0]      retire_inc;
    logic [CNT_WIDTH-1:0]  cnt_val [NB_CNT];
    logic [NB_CNT-1:0]     ovf_all;
    logic [CNT_WIDTH-1:0]  rd_cnt;
    logic [XLEN-1:0]       rd_mux;

    assign dec    = csr_decode(csr_addr_i, csr_we_i, NB_HPM);
    assign wr_cnt = csr_req_i && csr_we_i && (dec.sel == SEL_COUNTER);
    assign wr_lo  = wr_cnt && !dec.high;
    assign wr_hi  = wr_cnt && dec.high;
    assign wr_inh = csr_req_i && csr_we_i && (dec.sel == SEL_INHIBIT);

    assign retire_inc = (retire_cnt_i > RET_W'(NB_RETIRE)) ? RET_W'(NB_RETIRE) : retire_cnt_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            inhibit <= '0;
        else if (wr_inh)
            inhibit <= csr_wdata_i[NB_CNT-1:0] & INH_MASK;
    end

    // Slot 1 is the time CSR, which lives outside this block.
    for (genvar i = 0; i < NB_CNT; i++) begin : g_cnt
        if (i == 1) begin : g_time
            assign cnt_val[i] = '0;
            assign ovf_all[i] = 1'b0;
        end else if (i == 2) begin : g_instret
            hpm_counter #(
                .CNT_WIDTH (CNT_WIDTH),
                .XLEN      (XLEN),
                .INC_WIDTH (RET_W)
            ) u_counter (
                .clk     (clk),
                .reset_n (reset_n),
                .inc     (retire_inc),
                .inhibit (inhibit[i]),
                .we_lo   (wr_lo && dec.idx == 5'(i)),
                .we_hi   (wr_hi && dec.idx == 5'(i)),
                .wdata   (csr_wdata_i),
                .value   (cnt_val[i]),
                .ovf     (ovf_all[i])
            );
        end else begin : g_single
            hpm_counter #(
                .CNT_WIDTH (CNT_WIDTH),
                .XLEN      (XLEN),
                .INC_WIDTH (1)
            ) u_counter (
                .clk     (clk),
                .reset_n (reset_n),
                .inc     ((i == 0) ? 1'b1 : event_i[(i >= 3) ? i - HPM_BASE : 0]),
                .inhibit (inhibit[i]),
                .we_lo   (wr_lo && dec.idx == 5'(i)),
                .we_hi   (wr_hi && dec.idx == 5'(i)),
                .wdata   (csr_wdata_i),
                .value   (cnt_val[i]),
                .ovf     (ovf_all[i])
            );
        end
    end

    always_comb begin
        rd_cnt = '0;
        for (int unsigned i = 0; i < NB_CNT; i++) begin
            if (dec.idx == 5'(i))
                rd_cnt = cnt_val[i];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (dec.sel)
            SEL_INHIBIT: rd_mux = XLEN'(inhibit);
            SEL_COUNTER: begin
                if (dec.high)
                    rd_mux[CNT_WIDTH-XLEN-1:0] = rd_cnt[CNT_WIDTH-1:XLEN];
                else
                    rd_mux = rd_cnt[XLEN-1:0];
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_ack_o   <= 1'b0;
            csr_err_o   <= 1'b0;
            csr_rdata_o <= '0;
        end else begin
            csr_ack_o   <= csr_req_i;
            csr_err_o   <= csr_req_i && (dec.sel == SEL_ERR);
            csr_rdata_o <= (csr_req_i && !csr_we_i) ? rd_mux : '0;
        end
    end

    assign ovf_o = ovf_all;

endmodule
